// File: rtl/spi_reg_pkg.sv
`default_nettype none
// =============================================================================
// spi_reg_pkg : shared state encoding and command-byte constants for the
//               SPI register responder.
// Revision    : 1.0
// =============================================================================
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int CMD_RW_BIT   = 7;
   localparam int CMD_MB_BIT   = 6;
   localparam int SCLK_MIN_DIV = 16;

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// =============================================================================
// spi_in_sync : N-stage synchroniser with rise/fall pulses on the synced level.
// Revision    : 1.0
// =============================================================================
module spi_in_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic arst_n,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_sync <= {STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_rise =  r_sync[STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// =============================================================================
// spi_reg_responder : SPI mode-3 slave bridging an external master onto an
//                     8-bit register bus (ADXL345-style command framing).
// Revision          : 1.0
// =============================================================================
module spi_reg_responder
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              sclk_i,
   input  logic              cs_n_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic              reg_rd_o,
   input  logic [7:0]        reg_rdata_i,
   output logic              reg_wr_o,
   output logic [7:0]        reg_wdata_o,
   output logic              busy_o,
   output logic              frame_err_o
);

   localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_cs_rise;
   logic                   w_cs_fall;
   logic                   w_mosi;
   logic [7:0]             w_byte;
   logic [2:0]             w_bitcnt_nxt;
   logic                   w_partial;

   logic [SYNC_STAGES-1:0] r_mosi_sync;
   state_t                 r_state;
   logic [2:0]             r_bitcnt;
   logic [6:0]             r_rx;
   logic [7:0]             r_tx;
   logic [ADDR_W-1:0]      r_addr;
   logic                   r_rw;
   logic                   r_mb;
   logic                   r_rd;
   logic                   r_rd_d;
   logic                   r_wr;
   logic [7:0]             r_wdata;
   logic                   r_miso;
   logic                   r_oe;
   logic                   r_err;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .i_d    (sclk_i),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .i_d    (cs_n_i),
      .o_rise (w_cs_rise),
      .o_fall (w_cs_fall)
   );

   // Same depth as the sclk chain so a detected rise sees the matching MOSI bit.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_mosi_sync <= '0;
      end else begin
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      end
   end

   assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
   assign w_byte       = {r_rx, w_mosi};
   assign w_bitcnt_nxt = r_bitcnt + {2'b00, w_sclk_rise};
   assign w_partial    = (r_state != IDLE) && (w_bitcnt_nxt != 3'd0);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= IDLE;
         r_bitcnt <= 3'd0;
         r_rx     <= '0;
         r_tx     <= '0;
         r_addr   <= '0;
         r_rw     <= 1'b0;
         r_mb     <= 1'b0;
         r_rd     <= 1'b0;
         r_rd_d   <= 1'b0;
         r_wr     <= 1'b0;
         r_wdata  <= '0;
         r_miso   <= 1'b0;
         r_oe     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         r_err  <= 1'b0;
         r_rd_d <= r_rd;

         if (r_rd_d) begin
            r_tx <= reg_rdata_i;
         end
         // Write address advances only after its strobe has been seen.
         if (r_wr && r_mb) begin
            r_addr <= r_addr + c_ADDR_ONE;
         end

         if (w_cs_fall) begin
            r_state  <= CMD;
            r_bitcnt <= 3'd0;
            r_rx     <= '0;
            r_tx     <= '0;
            r_miso   <= 1'b0;
            r_oe     <= 1'b1;
         end else begin
            if ((r_state != IDLE) && w_sclk_rise) begin
               r_rx     <= w_byte[6:0];
               r_bitcnt <= w_bitcnt_nxt;
               if (r_bitcnt == 3'd7) begin
                  if (r_state == CMD) begin
                     r_addr  <= w_byte[ADDR_W-1:0];
                     r_rw    <= w_byte[CMD_RW_BIT];
                     r_mb    <= w_byte[CMD_MB_BIT];
                     r_rd    <= w_byte[CMD_RW_BIT];
                     r_state <= DATA;
                  end else if (r_rw) begin
                     // No prefetch once the master has already deselected.
                     if (r_mb) begin
                        r_addr <= r_addr + c_ADDR_ONE;
                     end
                     r_rd <= ~w_cs_rise;
                  end else begin
                     r_wdata <= w_byte;
                     r_wr    <= 1'b1;
                  end
               end
            end

            if ((r_state == DATA) && r_rw && w_sclk_fall) begin
               r_miso <= r_tx[7];
               r_tx   <= {r_tx[6:0], 1'b0};
            end

            if (w_cs_rise) begin
               r_state  <= IDLE;
               r_bitcnt <= 3'd0;
               r_miso   <= 1'b0;
               r_oe     <= 1'b0;
               r_err    <= w_partial;
            end
         end
      end
   end

   assign miso_o      = r_miso;
   assign miso_oe_o   = r_oe;
   assign reg_addr_o  = r_addr;
   assign reg_rd_o    = r_rd;
   assign reg_wr_o    = r_wr;
   assign reg_wdata_o = r_wdata;
   assign busy_o      = (r_state != IDLE);
   assign frame_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// =============================================================================
// tb_spi_reg_responder : mode-3 SPI master model with register-bus scoreboard.
// Revision             : 1.0
// =============================================================================
module tb_spi_reg_responder;
   import spi_reg_pkg::*;

   localparam int c_CLK_NS = 10;
   localparam int c_HALF   = (SCLK_MIN_DIV / 2) * c_CLK_NS;
   localparam int c_ADDR_W = 6;

   logic                clk = 1'b0;
   logic                arst_n;
   logic                sclk_i;
   logic                cs_n_i;
   logic                mosi_i;
   logic                miso_o;
   logic                miso_oe_o;
   logic [c_ADDR_W-1:0] reg_addr_o;
   logic                reg_rd_o;
   logic [7:0]          reg_rdata_i = 8'h00;
   logic                reg_wr_o;
   logic [7:0]          reg_wdata_o;
   logic                busy_o;
   logic                frame_err_o;

   int n_checks    = 0;
   int n_errors    = 0;
   int n_err_pulse = 0;

   logic [13:0] exp_wr_q[$];
   logic [5:0]  exp_rd_q[$];
   logic [7:0]  exp_miso_q[$];
   logic [13:0] wr_e;
   logic [5:0]  rd_e;

   spi_reg_responder #(.ADDR_W(c_ADDR_W), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .sclk_i      (sclk_i),
      .cs_n_i      (cs_n_i),
      .mosi_i      (mosi_i),
      .miso_o      (miso_o),
      .miso_oe_o   (miso_oe_o),
      .reg_addr_o  (reg_addr_o),
      .reg_rd_o    (reg_rd_o),
      .reg_rdata_i (reg_rdata_i),
      .reg_wr_o    (reg_wr_o),
      .reg_wdata_o (reg_wdata_o),
      .busy_o      (busy_o),
      .frame_err_o (frame_err_o)
   );

   always #(c_CLK_NS / 2) clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] reg_model(input logic [5:0] a);
      if (a == 6'h0A) return 8'h3C;
      return {2'b00, a} + 8'h10;
   endfunction

   // Register-bus side: answers reads, pops scoreboard entries on strobes.
   always @(negedge clk) begin
      if (arst_n) begin
         if (reg_rd_o) begin
            reg_rdata_i = reg_model(reg_addr_o);
            if (exp_rd_q.size() == 0) begin
               chk("rd_unexpected", 32'(reg_addr_o), 32'hFFFF_FFFF);
            end else begin
               rd_e = exp_rd_q.pop_front();
               chk("rd_addr", 32'(reg_addr_o), 32'(rd_e));
            end
         end
         if (reg_wr_o) begin
            chk("rd_wr_excl", 32'(reg_rd_o), 32'h0);
            if (exp_wr_q.size() == 0) begin
               chk("wr_unexpected", 32'({reg_addr_o, reg_wdata_o}), 32'hFFFF_FFFF);
            end else begin
               wr_e = exp_wr_q.pop_front();
               chk("wr_addr", 32'(reg_addr_o), 32'(wr_e[13:8]));
               chk("wr_data", 32'(reg_wdata_o), 32'(wr_e[7:0]));
            end
         end
         if (frame_err_o) n_err_pulse++;
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cs_last,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk_i = 1'b0;
         mosi_i = tx[7-i];
         #(c_HALF);
         rx = {rx[6:0], miso_o};
         if (cs_last && (i == nbits - 1)) cs_n_i = 1'b1;
         sclk_i = 1'b1;
         #(c_HALF);
      end
   endtask

   task automatic frame_begin();
      cs_n_i = 1'b0;
      #(c_HALF);
      chk("sel_busy", 32'(busy_o), 32'h1);
      chk("sel_oe", 32'(miso_oe_o), 32'h1);
   endtask

   task automatic frame_end(input bit cs_done);
      if (!cs_done) begin
         #(c_HALF);
         cs_n_i = 1'b1;
      end
      #(4 * c_HALF);
      chk("idle_busy", 32'(busy_o), 32'h0);
      chk("idle_oe", 32'(miso_oe_o), 32'h0);
      chk("wr_q_empty", 32'(exp_wr_q.size()), 32'h0);
      chk("rd_q_empty", 32'(exp_rd_q.size()), 32'h0);
   endtask

   task automatic wr_byte(input logic [7:0] d, input bit cs_last);
      logic [7:0] rx;
      spi_bits(d, 8, cs_last, rx);
      chk("wr_miso_zero", 32'(rx), 32'h0);
   endtask

   task automatic rd_byte(input logic [7:0] exp, input bit cs_last);
      logic [7:0] rx;
      exp_miso_q.push_back(exp);
      spi_bits(8'h00, 8, cs_last, rx);
      chk("rd_miso_byte", 32'(rx), 32'(exp_miso_q.pop_front()));
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         err0;
      logic [7:0] rx;
      arst_n = 1'b0;
      sclk_i = 1'b1;
      cs_n_i = 1'b1;
      mosi_i = 1'b0;
      #(2 * c_CLK_NS);
      chk("rst_flags", 32'({miso_o, miso_oe_o, reg_rd_o, reg_wr_o, busy_o, frame_err_o}), 32'h0);
      chk("rst_addr", 32'(reg_addr_o), 32'h0);
      chk("rst_wdata", 32'(reg_wdata_o), 32'h0);
      #(2 * c_CLK_NS);
      arst_n = 1'b1;
      #(4 * c_HALF);

      // Single write
      frame_begin();
      exp_wr_q.push_back({6'h05, 8'hA7});
      wr_byte(8'h05, 1'b0);
      wr_byte(8'hA7, 1'b0);
      frame_end(1'b0);
      chk("wr_no_err", 32'(n_err_pulse), 32'h0);

      // Single read; master deselects on the final rise so no prefetch follows
      frame_begin();
      exp_rd_q.push_back(6'h0A);
      wr_byte(8'h8A, 1'b0);
      rd_byte(8'h3C, 1'b1);
      frame_end(1'b1);

      // Burst read across the address wrap
      frame_begin();
      exp_rd_q.push_back(6'h3E);
      exp_rd_q.push_back(6'h3F);
      exp_rd_q.push_back(6'h00);
      wr_byte(8'hFE, 1'b0);
      rd_byte(8'h4E, 1'b0);
      rd_byte(8'h4F, 1'b0);
      rd_byte(8'h10, 1'b1);
      frame_end(1'b1);

      // Non-MB burst write
      frame_begin();
      exp_wr_q.push_back({6'h12, 8'h11});
      exp_wr_q.push_back({6'h12, 8'h22});
      wr_byte(8'h12, 1'b0);
      wr_byte(8'h11, 1'b0);
      wr_byte(8'h22, 1'b0);
      frame_end(1'b0);

      // Abort with a partial data byte
      err0 = n_err_pulse;
      frame_begin();
      wr_byte(8'h03, 1'b0);
      spi_bits(8'hF0, 5, 1'b0, rx);
      frame_end(1'b0);
      chk("abort_err_pulse", 32'(n_err_pulse - err0), 32'h1);
      frame_begin();
      exp_wr_q.push_back({6'h03, 8'h5A});
      wr_byte(8'h03, 1'b0);
      wr_byte(8'h5A, 1'b0);
      frame_end(1'b0);
      chk("after_abort_err", 32'(n_err_pulse - err0), 32'h1);

      // Reset in the middle of the second read byte
      frame_begin();
      exp_rd_q.push_back(6'h04);
      exp_rd_q.push_back(6'h05);
      wr_byte(8'hC4, 1'b0);
      rd_byte(8'h14, 1'b0);
      spi_bits(8'h00, 3, 1'b0, rx);
      arst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 32'({miso_o, miso_oe_o, reg_rd_o, reg_wr_o, busy_o, frame_err_o}), 32'h0);
      chk("mid_rst_addr", 32'(reg_addr_o), 32'h0);
      cs_n_i = 1'b1;
      sclk_i = 1'b1;
      mosi_i = 1'b0;
      #(c_HALF - 1);
      arst_n = 1'b1;
      #(4 * c_HALF);
      chk("mid_rst_rd_q", 32'(exp_rd_q.size()), 32'h0);

      // Post-reset write; deselect coincides with the 8th rise of the data byte
      frame_begin();
      exp_wr_q.push_back({6'h01, 8'h55});
      wr_byte(8'h01, 1'b0);
      wr_byte(8'h55, 1'b1);
      frame_end(1'b1);
      chk("total_err_pulses", 32'(n_err_pulse), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
